// File: rtl/vga_timing_gen_p_if.sv
// vga_timing_gen_p_if: pixel-source handshake (request + coordinate out, colour back)
interface vga_timing_gen_p_if #(parameter int CNT_W = 11);
  logic px_req;
  logic [CNT_W-1:0] px_x;
  logic [CNT_W-1:0] px_y;
  logic [23:0] px_rgb;
  modport master(output px_req, px_x, px_y, input px_rgb);
  modport slave(input px_req, px_x, px_y, output px_rgb);
endinterface

// File: rtl/vga_timing_gen_p.sv
// vga_timing_gen_p: parametrised VGA timing with 2-stage pixel pipeline (counters -> pins).
// Define VGA_PATTERN_EN to replace px_rgb with internal 8-bar colour pattern.
module vga_timing_gen_p #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int CLK_DIV = 2,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CNT_W = 11,
  parameter int FRAME_W = 16
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic enable,
  vga_timing_gen_p_if.master px,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic VGA_HS,
  output logic VGA_VS,
  output logic VGA_BLANK_N,
  output logic VGA_SYNC_N,
  output logic VGA_CLK,
  output logic frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  if (H_TOTAL - 1 >= 2 ** CNT_W || V_TOTAL - 1 >= 2 ** CNT_W) begin : g_cnt_w_chk
    $error("CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 2 || CLK_DIV % 2 != 0) begin : g_div_chk
    $error("CLK_DIV must be even and >= 2");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h, v;
  logic pix_tick, h_end, v_end, act, hs_a, vs_a;
  logic [23:0] rgb;

  assign pix_tick = enable && div_cnt == DIV_LAST;
  assign h_end = h == CNT_W'(H_TOTAL - 1);
  assign v_end = v == CNT_W'(V_TOTAL - 1);
  assign act = int'(h) < H_ACTIVE && int'(v) < V_ACTIVE;
  assign hs_a = int'(h) >= H_ACTIVE + H_FP && int'(h) < H_ACTIVE + H_FP + H_SYNC;
  assign vs_a = int'(v) >= V_ACTIVE + V_FP && int'(v) < V_ACTIVE + V_FP + V_SYNC;

  assign px.px_req = pix_tick && act;
  assign px.px_x = h;
  assign px.px_y = v;
  assign VGA_CLK = div_cnt >= DIV_HALF;
  assign VGA_SYNC_N = 1'b0;

`ifdef VGA_PATTERN_EN
  logic [2:0] bar;
  // bar index counts bar boundaries passed; the last bar absorbs the remainder
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) bar = int'(h) >= i * (H_ACTIVE / 8) ? 3'(i) : bar;
    rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  end
`else
  assign rgb = px.px_rgb;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      h <= '0;
      v <= '0;
      frame_cnt <= '0;
      frame_start <= 1'b0;
      VGA_HS <= !HS_POL;
      VGA_VS <= !VS_POL;
      VGA_BLANK_N <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      h <= '0;
      v <= '0;
      frame_start <= 1'b0;
      VGA_HS <= !HS_POL;
      VGA_VS <= !VS_POL;
      VGA_BLANK_N <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= '0;
    end else begin
      div_cnt <= pix_tick ? '0 : div_cnt + 1'b1;
      frame_start <= pix_tick && h_end && v_end;
      if (pix_tick) begin
        h <= h_end ? '0 : h + 1'b1;
        v <= h_end ? (v_end ? '0 : v + 1'b1) : v;
        frame_cnt <= h_end && v_end ? frame_cnt + 1'b1 : frame_cnt;
        VGA_HS <= hs_a ? HS_POL : !HS_POL;
        VGA_VS <= vs_a ? VS_POL : !VS_POL;
        VGA_BLANK_N <= act;
        {VGA_R, VGA_G, VGA_B} <= act ? rgb : '0;
      end
    end
  end
endmodule
